// File: rtl/alu_pkg.sv
// Shared opcodes and FSM state encoding for the sequential ALU.
// The MUL state exists only when ALU_SEQ_MUL_EN is defined.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
`ifdef ALU_SEQ_MUL_EN
    ST_MUL  = 2'd1,
`endif
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Unsigned shift-add multiplier: operands latched on start, one partial
// product per cycle; done/product are presented combinationally on the last step.
module alu_mul_iter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_next;
  logic [WIDTH:0]     sum;
  logic [CW-1:0]      cnt;
  logic               busy;

  // Low half holds the remaining multiplier bits; each step adds into the
  // high half and shifts the whole product right by one.
  always_comb begin
    sum       = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, (prod[0] ? mcand : {WIDTH{1'b0}})};
    prod_next = {sum, prod[WIDTH-1:1]};
  end

  assign done    = busy && (cnt == CW'(WIDTH - 1));
  assign product = prod_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand <= '0;
      prod  <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
    end else if (start) begin
      mcand <= a;
      prod  <= {{WIDTH{1'b0}}, b};
      cnt   <= '0;
      busy  <= 1'b1;
    end else if (busy) begin
      prod <= prod_next;
      cnt  <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready on both sides and status flags.
// Define ALU_SEQ_MUL_EN to build in the iterative multiplier (select 7).
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       select,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_n,
  output logic             flag_v,
  output state_t           state
);

  localparam int SW  = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  // Handshake: a transfer happens on any rising edge where valid and ready
  // are both high; a producer holds valid and data stable until it does.
  logic accept;
  assign in_ready = !rst && ((state == ST_IDLE) || ((state == ST_DONE) && out_ready));
  assign accept   = in_valid && in_ready;

  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;
  logic [WIDTH:0]   wide;
  logic [SW-1:0]    sh;

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    wide    = '0;
    sh      = b[SW-1:0];
    case (select)
      OP_ADD: begin
        wide    = {1'b0, a} + {1'b0, b};
        alu_res = wide[WIDTH-1:0];
        alu_c   = wide[WIDTH];
        alu_v   = (a[MSB] == b[MSB]) && (alu_res[MSB] != a[MSB]);
      end
      OP_SUB: begin
        // Bit WIDTH of the extended difference is the borrow (a < b).
        wide    = {1'b0, a} - {1'b0, b};
        alu_res = wide[WIDTH-1:0];
        alu_c   = wide[WIDTH];
        alu_v   = (a[MSB] != b[MSB]) && (alu_res[MSB] != a[MSB]);
      end
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_SHL: begin
        wide    = {1'b0, a} << sh;
        alu_res = wide[WIDTH-1:0];
        alu_c   = wide[WIDTH];
      end
      OP_SHR: begin
        wide    = {a, 1'b0} >> sh;
        alu_res = wide[WIDTH:1];
        alu_c   = wide[0];
      end
      default: ;
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  logic               is_mul;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;

  assign is_mul = (select == OP_MUL);

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (accept && is_mul),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_product)
  );
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      flag_z    <= 1'b0;
      flag_c    <= 1'b0;
      flag_n    <= 1'b0;
      flag_v    <= 1'b0;
    end else begin
      case (state)
`ifdef ALU_SEQ_MUL_EN
        ST_MUL: begin
          if (mul_done) begin
            result    <= mul_product[WIDTH-1:0];
            result_hi <= mul_product[2*WIDTH-1:WIDTH];
            flag_z    <= (mul_product == '0);
            flag_c    <= |mul_product[2*WIDTH-1:WIDTH];
            flag_v    <= |mul_product[2*WIDTH-1:WIDTH];
            flag_n    <= mul_product[MSB];
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end
        end
`endif
        default: begin
          if (accept) begin
`ifdef ALU_SEQ_MUL_EN
            if (is_mul) begin
              out_valid <= 1'b0;
              state     <= ST_MUL;
            end else
`endif
            begin
              result    <= alu_res;
              result_hi <= '0;
              flag_z    <= (alu_res == '0);
              flag_c    <= alu_c;
              flag_n    <= alu_res[MSB];
              flag_v    <= alu_v;
              out_valid <= 1'b1;
              state     <= ST_DONE;
            end
          end else if ((state == ST_IDLE) || out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule
